// File: rtl/dbg_axi_pkg.sv
// Shared types and helpers for the debug-to-bus bridge endpoints.
// Holds the FSM state encoding, AXI constants and the byte-lane mask helpers.
package dbg_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Contiguous byte-lane mask for an access of 1 << size_eff bytes (max 8 lanes).
    function automatic logic [7:0] lane_mask(input logic [1:0] size_eff);
        logic [7:0] m;
        case (size_eff)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Expand a per-lane mask into a per-bit data mask.
    function automatic logic [63:0] lane_bits(input logic [7:0] lanes);
        logic [63:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i*8 +: 8] = {8{lanes[i]}};
        end
        return b;
    endfunction

endpackage

// File: rtl/dbg_tog_sync.sv
// Toggle-handshake receiver: synchroniser, edge detector and post-reset ignore window.
// The edge flop always tracks the synchronised toggle, so dropped edges are consumed.
module dbg_tog_sync #(
    parameter int unsigned STAGES     = 2,
    parameter int unsigned IGNORE_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tog,
    input  logic en,
    output logic rec_c
);

    localparam int unsigned NS    = (STAGES < 2) ? 2 : STAGES;
    localparam int unsigned CNT_W = (IGNORE_CYC < 2) ? 1 : $clog2(IGNORE_CYC + 1);

    logic [NS-1:0]    sync_q;
    logic             edge_q;
    logic [CNT_W-1:0] ign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            ign_q  <= CNT_W'(IGNORE_CYC);
        end else begin
            sync_q <= {sync_q[NS-2:0], tog};
            edge_q <= sync_q[NS-1];
            if (ign_q != '0) begin
                ign_q <= ign_q - CNT_W'(1);
            end
        end
    end

    assign rec_c = (sync_q[NS-1] ^ edge_q) & (ign_q == '0) & en;

endmodule

// File: rtl/dbg_axi_rx_gen.sv
// Bus-side endpoint of the debug bridge: turns one toggled request into an AXI4
// single or 2-beat INCR transaction and returns data/response via a return toggle.
module dbg_axi_rx_gen
    import dbg_axi_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ID_W        = 9,
    parameter int unsigned AXI_ID      = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IGNORE_CYC  = 15,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                rx_clk,
    input  logic                rx_rstn,
    input  logic                tx_tog,
    input  logic [ADDR_W-1:0]   tx_mem_addr,
    input  logic                tx_mem_write,
    input  logic [DATA_W-1:0]   tx_mem_wdata,
    input  logic [2:0]          tx_mem_size,
    input  logic [6:0]          tx_mem_prot,
    input  logic                tx_mem_secen,
    output logic                rx_tog,
    output logic [DATA_W-1:0]   rx_mem_rdata,
    output logic [1:0]          rx_mem_resp,
    output logic                rx_mem_timeout,
    output logic                rx_busy,
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ID_W-1:0]     arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_W-1:0]     rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned LB    = (LANES == 8) ? 3 : 2;
    localparam int unsigned HI_W  = LB + 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    state_e              state;
    logic                rec_c;
    logic                is_write_q;
    logic [LB-1:0]       off_q;
    logic [HI_W-1:0]     hi_q;
    logic [DATA_W-1:0]   dmask_q;
    logic [LANES-1:0]    strb1_q;
    logic [DATA_W-1:0]   data1_q;
    logic [ADDR_W-1:0]   ax_addr_q;
    logic [7:0]          ax_len_q;
    logic [2:0]          ax_prot_q;
    logic [TO_W-1:0]     tcnt_q;
    logic                rbeat_q;
    logic [DATA_W-1:0]   racc_q;
    logic [1:0]          racc_resp_q;

    dbg_tog_sync #(
        .STAGES     (SYNC_STAGES),
        .IGNORE_CYC (IGNORE_CYC)
    ) u_sync (
        .clk   (rx_clk),
        .rst_n (rx_rstn),
        .tog   (tx_tog),
        .en    (state == ST_IDLE),
        .rec_c (rec_c)
    );

    assign awid    = ID_W'(AXI_ID);
    assign arid    = ID_W'(AXI_ID);
    assign awburst = BURST_INCR;
    assign arburst = BURST_INCR;
    assign awsize  = 3'(LB);
    assign arsize  = 3'(LB);
    assign awaddr  = ax_addr_q;
    assign araddr  = ax_addr_q;
    assign awlen   = ax_len_q;
    assign arlen   = ax_len_q;
    assign awprot  = ax_prot_q;
    assign arprot  = ax_prot_q;

    // Request geometry, evaluated on the live request fields at capture time.
    logic [1:0]       size_eff_c;
    logic [LB-1:0]    off_c;
    logic [HI_W-1:0]  hi_c;
    logic [3:0]       bytes_c;
    logic             split_c;
    logic [LANES-1:0] mask_c;

    always_comb begin
        size_eff_c = (tx_mem_size > 3'(LB)) ? 2'(LB) : tx_mem_size[1:0];
        off_c      = tx_mem_addr[LB-1:0];
        hi_c       = HI_W'(LANES) - {1'b0, off_c};
        bytes_c    = 4'(1) << size_eff_c;
        split_c    = (5'(off_c) + 5'(bytes_c)) > 5'(LANES);
        mask_c     = LANES'(lane_mask(size_eff_c));
    end

    // Read assembly and worst-case response including the beat on the bus now.
    logic [DATA_W-1:0] rd_c;
    logic [1:0]        rresp_max_c;
    logic              aw_hs_c, w_hs_c, ar_hs_c, b_hs_c, r_hs_c, done_c;
    logic              pend_c, to_hit_c;

    always_comb begin
        rd_c        = (rbeat_q ? (racc_q | (rdata << {hi_q, 3'b000}))
                               : (rdata >> {off_q, 3'b000})) & dmask_q;
        rresp_max_c = (rbeat_q && (racc_resp_q > rresp)) ? racc_resp_q : rresp;
        aw_hs_c     = awvalid & awready;
        w_hs_c      = wvalid & wready;
        ar_hs_c     = arvalid & arready;
        b_hs_c      = bvalid & bready;
        r_hs_c      = rvalid & rready;
        done_c      = is_write_q ? b_hs_c : (r_hs_c & rlast);
        pend_c      = (awvalid & ~awready) | (wvalid & ~(wready & wlast)) | (arvalid & ~arready);
        to_hit_c    = (TIMEOUT_CYC != 0) && (tcnt_q == TO_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge rx_clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            state          <= ST_IDLE;
            rx_tog         <= 1'b0;
            rx_mem_rdata   <= '0;
            rx_mem_resp    <= RESP_OKAY;
            rx_mem_timeout <= 1'b0;
            rx_busy        <= 1'b0;
            awvalid        <= 1'b0;
            wvalid         <= 1'b0;
            wstrb          <= '0;
            wdata          <= '0;
            wlast          <= 1'b0;
            arvalid        <= 1'b0;
            bready         <= 1'b0;
            rready         <= 1'b0;
            is_write_q     <= 1'b0;
            off_q          <= '0;
            hi_q           <= '0;
            dmask_q        <= '0;
            strb1_q        <= '0;
            data1_q        <= '0;
            ax_addr_q      <= '0;
            ax_len_q       <= '0;
            ax_prot_q      <= '0;
            tcnt_q         <= '0;
            rbeat_q        <= 1'b0;
            racc_q         <= '0;
            racc_resp_q    <= RESP_OKAY;
        end else begin
            // Address/data valids drop only on their own handshakes, in any state.
            if (aw_hs_c) awvalid <= 1'b0;
            if (ar_hs_c) arvalid <= 1'b0;
            if (w_hs_c) begin
                if (wlast) begin
                    wvalid <= 1'b0;
                end else begin
                    wstrb <= strb1_q;
                    wdata <= data1_q;
                    wlast <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (rec_c) begin
                        state       <= ST_ISSUE;
                        rx_busy     <= 1'b1;
                        bready      <= 1'b1;
                        rready      <= 1'b1;
                        is_write_q  <= tx_mem_write;
                        off_q       <= off_c;
                        hi_q        <= hi_c;
                        dmask_q     <= DATA_W'(lane_bits(lane_mask(size_eff_c)));
                        ax_addr_q   <= {tx_mem_addr[ADDR_W-1:LB], LB'(0)};
                        ax_len_q    <= {7'b0, split_c};
                        ax_prot_q   <= tx_mem_prot[2:0] & {1'b1, tx_mem_secen, 1'b1};
                        awvalid     <= tx_mem_write;
                        wvalid      <= tx_mem_write;
                        arvalid     <= ~tx_mem_write;
                        wstrb       <= mask_c << off_c;
                        wdata       <= tx_mem_wdata << {off_c, 3'b000};
                        wlast       <= ~split_c;
                        strb1_q     <= mask_c >> hi_c;
                        data1_q     <= tx_mem_wdata >> {hi_c, 3'b000};
                        tcnt_q      <= '0;
                        rbeat_q     <= 1'b0;
                        racc_q      <= '0;
                        racc_resp_q <= RESP_OKAY;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    // A real completion on the timeout cycle takes priority.
                    if (done_c) begin
                        rx_tog         <= ~rx_tog;
                        rx_mem_rdata   <= is_write_q ? '0 : rd_c;
                        rx_mem_resp    <= is_write_q ? bresp : rresp_max_c;
                        rx_mem_timeout <= 1'b0;
                        state          <= ST_IDLE;
                        rx_busy        <= 1'b0;
                        bready         <= 1'b0;
                        rready         <= 1'b0;
                    end else if (to_hit_c) begin
                        rx_tog         <= ~rx_tog;
                        rx_mem_rdata   <= '0;
                        rx_mem_resp    <= RESP_SLVERR;
                        rx_mem_timeout <= 1'b1;
                        state          <= ST_DRAIN;
                    end else begin
                        tcnt_q <= tcnt_q + TO_W'(1);
                        if (r_hs_c) begin
                            racc_q      <= rd_c;
                            racc_resp_q <= rresp_max_c;
                            rbeat_q     <= 1'b1;
                        end
                        if (state == ST_ISSUE && !pend_c) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Late responses are swallowed; leave once the final one arrives.
                    if (done_c) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                        bready  <= 1'b0;
                        rready  <= 1'b0;
                        awvalid <= 1'b0;
                        wvalid  <= 1'b0;
                        arvalid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic unused;
    assign unused = ^{bid, rid, tx_mem_prot[6:3]};

endmodule
